// File: rtl/spi_multi_pkg.sv
//------------------------------------------------------------------------------
// Module      : spi_multi_pkg
// Description : Shared types and constants for the multi-select SPI master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int SS_TRIG = 0;
    localparam int SS_CH1  = 1;
    localparam int SS_CH2  = 2;
    localparam int SS_CH3  = 3;
    localparam int SS_EEP  = 4;

    // Half an SCLK period in clk cycles; also the SETUP/HOLD guard length.
    function automatic int half_div(input int div);
        return div / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
//------------------------------------------------------------------------------
// Module      : spi_sclk_gen
// Description : SCLK divider; runs only while enabled, cleared otherwise.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_sclk_gen #(
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    import spi_multi_pkg::*;

    localparam int                HALF     = half_div(SCLK_DIV);
    localparam int                CNT_W    = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // SCLK is registered from the next count so it tracks cnt without a comb path.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        sclk_d = en_i && (cnt_d >= CNT_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = en_i && (cnt_q == CNT_PRE);
    assign fall_stb_o = en_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_mstr_multi_ss.sv
//------------------------------------------------------------------------------
// Module      : spi_mstr_multi_ss
// Description : Mode-0 MSB-first SPI master with registered slave-select decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_mstr_multi_ss #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_SS   = 5,
    parameter  int SCLK_DIV = 16,
    localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] data_in,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n
);
    import spi_multi_pkg::*;

    localparam int               HALF     = half_div(SCLK_DIV);
    localparam int               PH_W     = $clog2(SCLK_DIV);
    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                sample_q, sample_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;

    logic                sclk_en, sclk, rise_stb, fall_stb;
    logic [31:0]         sel_ext;
    logic                sel_ok;
    logic [NUM_SS-1:0]   dec_n;

    assign sclk_en = (state_q == ST_XFER);

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (sclk_en),
        .sclk_o     (sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    // Out-of-range indices must never reach the decoder outputs.
    assign sel_ext = 32'(ss_sel);
    assign sel_ok  = (sel_ext < 32'(NUM_SS));

    always_comb begin
        dec_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            dec_n[i] = (sel_ext != 32'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        ss_n_d    = ss_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        data_in_d = data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (wrt) begin
                    if (sel_ok) begin
                        shift_d = data_out;
                        mosi_d  = data_out[DATA_W-1];
                        ss_n_d  = dec_n;
                        busy_d  = 1'b1;
                        ph_d    = '0;
                        bit_d   = '0;
                        state_d = ST_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = ST_XFER;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (rise_stb) begin
                    sample_d = MISO;
                end
                if (fall_stb) begin
                    shift_d = {shift_q[DATA_W-2:0], sample_q};
                    mosi_d  = shift_q[DATA_W-2];
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (ph_q == PH_LAST) begin
                    ph_d      = '0;
                    ss_n_d    = '1;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    data_in_d = shift_q;
                    state_d   = ST_IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            sample_q  <= 1'b0;
            ss_n_q    <= '1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            data_in_q <= data_in_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign data_in = data_in_q;
    assign SCLK    = sclk;
    assign MOSI    = mosi_q;
    assign SS_n    = ss_n_q;

endmodule

`default_nettype wire

// File: doc/spi_mstr_multi_ss.md
Name: spi_mstr_multi_ss

Overview:
Parametrised SPI master with an integrated, registered slave-select decoder, replacing the external single-SS-plus-decode arrangement.
Drives NUM_SS active-low selects from a per-transaction index. Rejects out-of-range indices instead of asserting any select.
Sits between dig_core (command/config side) and the AFE gain pots, trigger-level pot and calibration EEPROM. SPI mode 0, MSB first.

Parameters:
DATA_W, 16, bits per transaction
NUM_SS, 5, number of slave selects (index 0=trig, 1..3=ch1..ch3, 4=EEP)
SCLK_DIV, 16, clk cycles per SCLK period; even, >=4
SS_W, $clog2(NUM_SS) (min 1), width of ss_sel (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wrt  in  1  start request, single-cycle pulse
ss_sel  in  SS_W  target slave index, sampled with wrt
data_out  in  DATA_W  word to shift out, sampled with wrt
busy  out  1  transaction in progress
done  out  1  one-cycle pulse, transaction complete
err  out  1  one-cycle pulse, wrt rejected due to invalid ss_sel
data_in  out  DATA_W  word shifted in from MISO; valid from done, held until next done
SCLK  out  1  SPI clock, idles low
MOSI  out  1  SPI data out
MISO  in  1  SPI data in
SS_n  out  NUM_SS  active-low selects, at most one low at any time

Behaviour:
- Interface timing: one clock clk; reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: SS_n all ones, SCLK=0, MOSI=0, busy=0, done=0, err=0, data_in=0, FSM=IDLE.
- A reset mid-transaction deselects all slaves and sets SCLK low on that same edge. No done pulse is generated.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - wrt with ss_sel<NUM_SS: latch data_out into the shift register and latch ss_sel. Go to SETUP. busy=1 and SS_n[sel]=0 from the next cycle.
  - wrt with ss_sel>=NUM_SS: err=1 for one cycle. No SS_n, SCLK or busy change. Stay in IDLE.
- SETUP: SCLK_DIV/2 cycles with SCLK low, MOSI = shift MSB. Then go to XFER.
- XFER: divider cnt runs 0..SCLK_DIV-1.
  - SCLK=1 while cnt>=SCLK_DIV/2.
  - On the rising-edge cycle (cnt -> SCLK_DIV/2), MISO is captured into a sample flop.
  - On cnt wrap, the shift register shifts left with the sample entering the LSB, and MOSI updates to the new MSB.
  - After DATA_W periods, go to HOLD.
- HOLD: SCLK_DIV/2 cycles with SCLK low and SS_n still asserted. Then return to IDLE. On that edge: SS_n all high, busy=0, done=1, data_in = shift register.
- Latency: wrt accepted at cycle 0 -> done at cycle 1+(DATA_W+1)*SCLK_DIV. Defaults give cycle 273.
- wrt while busy=1 is ignored: no err, transaction unaffected.
- wrt in the done cycle is accepted. Selects stay high for at least 1 clk between transactions.
- ss_sel and data_out are don't-care except in the wrt cycle.

Decomposition:
- Package spi_multi_pkg: FSM state enum, SCLK_DIV/2 constant helper, SS index constants (SS_TRIG=0, SS_CH1..SS_CH3=1..3, SS_EEP=4).
- Sub-module spi_sclk_gen: divider counter emitting sclk, rise_stb and fall_stb. It is enabled only in XFER and cleared otherwise.
- Decode, shift register and FSM stay in the top module.

Test Plan:
- Defaults; wrt, ss_sel=1, data_out=16'hA5C3; slave returns 16'h0001 -> only SS_n[1] low for cycles 1..272; 16 SCLK rises; MOSI bits A5C3 MSB first; done at cycle 273; data_in=16'h0001.
- ss_sel=5 and ss_sel=7 with wrt -> err pulses one cycle each; SS_n stays 5'b11111; busy stays 0; SCLK never toggles.
- wrt with ss_sel=4 mid-transfer to slave 0 -> ignored; transfer to slave 0 completes unchanged; SS_n[4] never low.
- Back-to-back: wrt in the done cycle, ss_sel 0 then 4 -> SS_n high for exactly 1 clk between; never two selects low together.
- rst asserted at cycle 100 of a transfer -> SS_n all high, SCLK=0, busy=0 next edge; no done; a new wrt afterwards completes normally.
- DATA_W=8, SCLK_DIV=4, NUM_SS=3: data 8'h3C, MISO=8'hF0 -> done at cycle 37; data_in=8'hF0; ss_sel=3 -> err.
